// File: rtl/rvm_mem_ctrl_pkg.sv
// Shared constants and types for the rvm memory access controller.
// Size codes and port ids match the values used elsewhere in the core.
package rvm_mem_ctrl_pkg;

  localparam logic [1:0] RVM_MEM_SIZE_B = 2'd0;
  localparam logic [1:0] RVM_MEM_SIZE_H = 2'd1;
  localparam logic [1:0] RVM_MEM_SIZE_W = 2'd2;

  localparam logic RVM_MEM_PORT_F = 1'b0;
  localparam logic RVM_MEM_PORT_D = 1'b1;

  // Request fields captured at grant time and held for the whole access.
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic        wen;
    logic [31:0] wdata;
    logic        port;
  } mem_req_t;

endpackage

// File: rtl/rvm_mem_lanes.sv
// Byte-lane steering: byte enables, store-data replication, load extraction
// and the alignment check. Purely combinational.
module rvm_mem_lanes
  import rvm_mem_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  b_en,
  output logic [31:0] lane_wdata,
  output logic [31:0] ext_rdata,
  output logic        misaligned
);

  logic [31:0] shifted;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    shifted    = rdata >> {addr_lo, 3'b000};
    b_en       = 4'b1111;
    lane_wdata = wdata;
    ext_rdata  = shifted;
    misaligned = 1'b0;
    case (size)
      RVM_MEM_SIZE_B: begin
        b_en       = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        ext_rdata  = {{24{sgn & shifted[7]}}, shifted[7:0]};
      end
      RVM_MEM_SIZE_H: begin
        b_en       = 4'b0011 << {addr_lo[1], 1'b0};
        lane_wdata = {2{wdata[15:0]}};
        ext_rdata  = {{16{sgn & shifted[15]}}, shifted[15:0]};
        misaligned = addr_lo[0];
      end
      RVM_MEM_SIZE_W: begin
        misaligned = |addr_lo;
      end
      default: begin
        b_en       = 4'b0000;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rvm_mem_ctrl.sv
// Single-port memory controller: round-robin arbitration of fetch and
// load/store requesters, sequenced IDLE -> ACCESS -> RESP through mem_stall.
module rvm_mem_ctrl
  import rvm_mem_ctrl_pkg::*;
#(
  parameter bit FETCH_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_rsp_valid,
  output logic [31:0] f_rdata,
  output logic        f_error,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rdata,
  output logic        d_error,
  output logic        busy,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic        mem_c_en,
  output logic [3:0]  mem_b_en,
  input  logic        mem_error,
  input  logic        mem_stall
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]  state;
  mem_req_t    req_q;
  mem_req_t    cand;
  mem_req_t    lane_req;
  logic        last_grant;
  logic        grant_port;
  logic        any_req;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [3:0]  b_en;
  logic [31:0] lane_wdata;
  logic [31:0] ext_rdata;
  logic        misaligned;

  assign any_req = f_req | d_req;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    grant_port = RVM_MEM_PORT_F;
    if (f_req && d_req)
      grant_port = ~last_grant;
    else if (d_req)
      grant_port = RVM_MEM_PORT_D;
  end

  always_comb begin
    cand = '0;
    if (grant_port == RVM_MEM_PORT_F) begin
      cand.addr = f_addr;
      cand.size = RVM_MEM_SIZE_W;
      cand.port = RVM_MEM_PORT_F;
    end else begin
      cand.addr  = d_addr;
      cand.size  = d_size;
      cand.sgn   = d_signed;
      cand.wen   = d_wen;
      cand.wdata = d_wdata;
      cand.port  = RVM_MEM_PORT_D;
    end
  end

  // The single lane unit checks alignment of the incoming request in IDLE
  // and steers the latched request for the rest of the access.
  assign lane_req = (state == ST_IDLE) ? cand : req_q;

  rvm_mem_lanes u_lanes (
    .size       (lane_req.size),
    .addr_lo    (lane_req.addr[1:0]),
    .sgn        (lane_req.sgn),
    .wdata      (lane_req.wdata),
    .rdata      (mem_rdata),
    .b_en       (b_en),
    .lane_wdata (lane_wdata),
    .ext_rdata  (ext_rdata),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) begin
      state       <= ST_IDLE;
      req_q       <= '0;
      last_grant  <= FETCH_FIRST ? RVM_MEM_PORT_D : RVM_MEM_PORT_F;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            req_q      <= cand;
            last_grant <= cand.port;
            if (misaligned) begin
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
              state       <= ST_RESP;
            end else begin
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (!mem_stall) begin
            rsp_err_q   <= mem_error;
            rsp_rdata_q <= (req_q.wen || mem_error) ? 32'h0 : ext_rdata;
            state       <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign mem_c_en = (state == ST_ACCESS);
  assign mem_addr  = mem_c_en ? {req_q.addr[31:2], 2'b00} : 32'h0;
  assign mem_b_en  = mem_c_en ? b_en : 4'h0;
  assign mem_wdata = mem_c_en ? lane_wdata : 32'h0;

  assign f_rsp_valid = (state == ST_RESP) && (req_q.port == RVM_MEM_PORT_F);
  assign d_rsp_valid = (state == ST_RESP) && (req_q.port == RVM_MEM_PORT_D);
  assign f_rdata = f_rsp_valid ? rsp_rdata_q : 32'h0;
  assign d_rdata = d_rsp_valid ? rsp_rdata_q : 32'h0;
  assign f_error = f_rsp_valid & rsp_err_q;
  assign d_error = d_rsp_valid & rsp_err_q;

endmodule

// File: tb/tb_rvm_mem_ctrl.sv
// Directed bench for rvm_mem_ctrl: a table of single accesses plus
// hand-written round-robin and reset-during-access sequences.
module tb_rvm_mem_ctrl;
  import rvm_mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        f_req, d_req, d_wen, d_signed, mem_error, mem_stall;
  logic [31:0] f_addr, d_addr, d_wdata, mem_rdata;
  logic [1:0]  d_size;
  logic        f_rsp_valid, f_error, d_rsp_valid, d_error, busy, mem_c_en;
  logic [31:0] f_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_b_en;

  int n_vec  = 0;
  int n_miss = 0;

  rvm_mem_ctrl #(.FETCH_FIRST(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .f_req(f_req), .f_addr(f_addr), .f_rsp_valid(f_rsp_valid), .f_rdata(f_rdata), .f_error(f_error),
    .d_req(d_req), .d_wen(d_wen), .d_size(d_size), .d_signed(d_signed), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata), .d_error(d_error),
    .busy(busy), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_c_en(mem_c_en), .mem_b_en(mem_b_en), .mem_error(mem_error), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fetch;
    logic        wen;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err_in;
    int          stalls;
    logic [3:0]  exp_ben;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    f_req = 0; d_req = 0; d_wen = 0; d_signed = 0; d_size = 0;
    f_addr = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 0; mem_error = 0; mem_stall = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    logic  vld, ovld;
    logic [31:0] rd;
    logic  er;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    if (v.fetch) begin
      f_req = 1; f_addr = v.addr;
    end else begin
      d_req = 1; d_addr = v.addr; d_size = v.size; d_signed = v.sgn;
      d_wen = v.wen; d_wdata = v.wdata;
    end
    mem_stall = 0; mem_rdata = 0; mem_error = 0;
    @(negedge clk);
    if (!v.exp_mis) begin
      for (int k = 0; k <= v.stalls; k++) begin
        mem_stall = (k < v.stalls);
        mem_rdata = v.rdata;
        mem_error = v.err_in;
        check({tag, " c_en"}, mem_c_en, 1'b1);
        check({tag, " addr"}, mem_addr, {v.addr[31:2], 2'b00});
        check({tag, " b_en"}, mem_b_en, v.exp_ben);
        if (v.wen) check({tag, " wdata"}, mem_wdata, v.exp_wdata);
        check({tag, " early_rsp"}, f_rsp_valid | d_rsp_valid, 1'b0);
        @(negedge clk);
      end
      mem_stall = 0; mem_error = 0;
    end
    vld  = v.fetch ? f_rsp_valid : d_rsp_valid;
    ovld = v.fetch ? d_rsp_valid : f_rsp_valid;
    rd   = v.fetch ? f_rdata : d_rdata;
    er   = v.fetch ? f_error : d_error;
    check({tag, " rsp_valid"}, vld, 1'b1);
    check({tag, " other_valid"}, ovld, 1'b0);
    check({tag, " rdata"}, rd, v.exp_rdata);
    check({tag, " error"}, er, v.exp_err);
    check({tag, " resp_c_en"}, mem_c_en, 1'b0);
    f_req = 0; d_req = 0;
    @(negedge clk);
    check({tag, " idle_busy"}, busy, 1'b0);
    check({tag, " idle_valid"}, f_rsp_valid | d_rsp_valid, 1'b0);
  endtask

  initial begin
    //              fetch wen size            sgn addr        wdata         rdata         err st ben   exp_wdata     exp_rdata     err mis
    vecs[0]  = '{1, 0, RVM_MEM_SIZE_W, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 4'hF, 32'h0,        32'hDEADBEEF, 0, 0};
    vecs[1]  = '{0, 0, RVM_MEM_SIZE_B, 1, 32'h203, 32'h0,        32'h80FF0000, 0, 0, 4'h8, 32'h0,        32'hFFFFFF80, 0, 0};
    vecs[2]  = '{0, 0, RVM_MEM_SIZE_B, 0, 32'h203, 32'h0,        32'h80FF0000, 0, 0, 4'h8, 32'h0,        32'h00000080, 0, 0};
    vecs[3]  = '{0, 1, RVM_MEM_SIZE_H, 0, 32'h12,  32'h1234ABCD, 32'hFFFFFFFF, 0, 3, 4'hC, 32'hABCDABCD, 32'h0,        0, 0};
    vecs[4]  = '{0, 0, RVM_MEM_SIZE_W, 0, 32'h6,   32'h0,        32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        1, 1};
    vecs[5]  = '{1, 0, RVM_MEM_SIZE_W, 0, 32'h40,  32'h0,        32'h12345678, 1, 1, 4'hF, 32'h0,        32'h0,        1, 0};
    vecs[6]  = '{0, 0, RVM_MEM_SIZE_H, 1, 32'h22,  32'h0,        32'h80017FFF, 0, 0, 4'hC, 32'h0,        32'hFFFF8001, 0, 0};
    vecs[7]  = '{0, 0, RVM_MEM_SIZE_H, 0, 32'h20,  32'h0,        32'h8001F00D, 0, 0, 4'h3, 32'h0,        32'h0000F00D, 0, 0};
    vecs[8]  = '{0, 1, RVM_MEM_SIZE_B, 0, 32'h31,  32'h000000A5, 32'h0,        0, 2, 4'h2, 32'hA5A5A5A5, 32'h0,        0, 0};
    vecs[9]  = '{0, 1, RVM_MEM_SIZE_W, 0, 32'h44,  32'hCAFEF00D, 32'h0,        0, 0, 4'hF, 32'hCAFEF00D, 32'h0,        0, 0};
    vecs[10] = '{1, 0, RVM_MEM_SIZE_W, 0, 32'h102, 32'h0,        32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        1, 1};
    vecs[11] = '{0, 0, 2'd3,           0, 32'h50,  32'h0,        32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        1, 1};
    vecs[12] = '{0, 0, RVM_MEM_SIZE_H, 0, 32'h15,  32'h0,        32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        1, 1};
    vecs[13] = '{0, 0, RVM_MEM_SIZE_B, 1, 32'h201, 32'h0,        32'h00007F00, 0, 0, 4'h2, 32'h0,        32'h0000007F, 0, 0};
    vecs[14] = '{0, 0, RVM_MEM_SIZE_W, 0, 32'h8,   32'h0,        32'h55555555, 1, 0, 4'hF, 32'h0,        32'h0,        1, 0};
    vecs[15] = '{0, 1, RVM_MEM_SIZE_H, 0, 32'h10,  32'hFFFF8001, 32'h0,        0, 0, 4'h3, 32'h80018001, 32'h0,        0, 0};

    idle_inputs();
    resetn = 0;
    #12;
    check("reset busy", busy, 1'b0);
    check("reset c_en", mem_c_en, 1'b0);
    check("reset addr", mem_addr, 32'h0);
    check("reset valid", f_rsp_valid | d_rsp_valid, 1'b0);

    // Both ports request continuously from reset: grants alternate F, D, F, D.
    f_req = 1; f_addr = 32'h1000;
    d_req = 1; d_addr = 32'h2000; d_size = RVM_MEM_SIZE_W;
    mem_rdata = 32'h11112222;
    @(negedge clk);
    resetn = 1;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      check($sformatf("rr%0d addr", g), mem_addr, (g % 2 == 0) ? 32'h1000 : 32'h2000);
      @(negedge clk);
      check($sformatf("rr%0d f_valid", g), f_rsp_valid, (g % 2 == 0) ? 1'b1 : 1'b0);
      check($sformatf("rr%0d d_valid", g), d_rsp_valid, (g % 2 == 0) ? 1'b0 : 1'b1);
      @(negedge clk);
      check($sformatf("rr%0d idle", g), busy, 1'b0);
    end
    idle_inputs();

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Reset while a fetch is stalled in ACCESS.
    @(negedge clk);
    f_req = 1; f_addr = 32'h300; mem_stall = 1;
    @(negedge clk);
    check("rst_mid c_en before", mem_c_en, 1'b1);
    @(negedge clk);
    #2 resetn = 0;
    #1;
    check("rst_mid busy", busy, 1'b0);
    check("rst_mid c_en", mem_c_en, 1'b0);
    check("rst_mid addr", mem_addr, 32'h0);
    check("rst_mid b_en", mem_b_en, 4'h0);
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_mid no_rsp", f_rsp_valid | d_rsp_valid, 1'b0);
    end
    resetn = 1;
    run_vec(16, '{1, 0, RVM_MEM_SIZE_W, 0, 32'h300, 32'h0, 32'hA5A55A5A, 0, 0, 4'hF, 32'h0, 32'hA5A55A5A, 0, 0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
